// File: rtl/mdc_switch_pkg.sv
// Shared types for the MDC stream switch: reconfiguration state, error bit indices, route-table lookup.
// Combinational helpers only; no latency or backpressure of its own.
package mdc_switch_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } sw_state_e;

    localparam int ERR_OVF = 0;
    localparam int ERR_ID  = 1;

    // Widest flattened route table the lookup helper accepts.
    localparam int ROUTE_TBL_W = 1024;

    function automatic int route_field(input logic [ROUTE_TBL_W-1:0] tbl,
                                       input int c,
                                       input int j,
                                       input int num_out,
                                       input int rw);
        return int'(32'(tbl >> ((c * num_out + j) * rw))) & ((1 << rw) - 1);
    endfunction

endpackage

// File: rtl/mdc_stream_buf2.sv
// Two-entry per-output token buffer; a pushed token is visible at head_o on the next cycle.
// Never refuses internally: the caller pushes only while count_o < 2.
module mdc_stream_buf2 #(
    parameter int W = 32
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push_i,
    input  logic [W-1:0] push_dat_i,
    input  logic         pop_i,
    output logic [1:0]   count_o,
    output logic [W-1:0] head_o
);

    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q, rd_ptr_q;
    logic [1:0]   cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 2'(push_i) - 2'(pop_i);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_dat_i;
            end
            wr_ptr_q <= wr_ptr_q ^ push_i;
            rd_ptr_q <= rd_ptr_q ^ pop_i;
            cnt_q    <= cnt_d;
        end
    end

    assign count_o = cnt_q;
    assign head_o  = mem_q[rd_ptr_q];

endmodule

// File: rtl/mdc_stream_switch.sv
// NxM stream switch with table-driven routing, 2-deep output buffers and drain-before-reconfigure.
// One cycle input-to-output latency; in_full asserted for unrouted inputs, full buffers, or while reconfiguring.
module mdc_stream_switch
    import mdc_switch_pkg::*;
#(
    parameter int NUM_IN  = 2,
    parameter int NUM_OUT = 2,
    parameter int SIZE    = 32,
    parameter int ID_W    = 8,
    parameter int NUM_CFG = 4,
    parameter logic [NUM_CFG*NUM_OUT*($clog2(NUM_IN)+1)-1:0] ROUTE = 16'h6814
) (
    input  logic [0:0]            clock,
    input  logic [0:0]            reset,
    input  logic [NUM_IN*SIZE-1:0]  in_data,
    input  logic [NUM_IN-1:0]       in_wr,
    output logic [NUM_IN-1:0]       in_full,
    output logic [NUM_OUT*SIZE-1:0] out_data,
    output logic [NUM_OUT-1:0]      out_wr,
    input  logic [NUM_OUT-1:0]      out_full,
    input  logic [ID_W-1:0]         ID,
    output logic [ID_W-1:0]         active_id,
    output logic                    cfg_busy,
    output logic [1:0]              err,
    input  logic                    err_clr,
    output logic [NUM_OUT*32-1:0]   tok_cnt
);

    localparam int RW = $clog2(NUM_IN) + 1;

    sw_state_e                     state_q, state_d;
    logic [NUM_OUT-1:0][RW-1:0]    route_q, route_d;
    logic [ID_W-1:0]               active_id_q, active_id_d;
    logic [1:0]                    err_q, err_d, err_set;
    logic [NUM_OUT-1:0][31:0]      tok_q, tok_d;
    logic [NUM_OUT-1:0]            push, pop;
    logic [NUM_OUT-1:0][SIZE-1:0]  push_dat, head;
    logic [NUM_OUT-1:0][1:0]       cnt;
    logic [NUM_IN-1:0]             routed, in_full_c;
    logic                          id_ok, all_empty;

    assign id_ok = (32'(ID) < 32'(NUM_CFG));

    // Outputs claim inputs in index order, so a duplicated input stays with the lowest output.
    always_comb begin
        routed    = '0;
        in_full_c = '1;
        push      = '0;
        push_dat  = '0;
        for (int j = 0; j < NUM_OUT; j++) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (32'(route_q[j]) == 32'(i) && !routed[i]) begin
                    routed[i]    = 1'b1;
                    in_full_c[i] = (state_q != ST_RUN) || (cnt[j] == 2'd2);
                    push[j]      = in_wr[i] && !in_full_c[i];
                    push_dat[j]  = in_data[i*SIZE +: SIZE];
                end
            end
        end
    end

    always_comb begin
        all_empty = 1'b1;
        for (int j = 0; j < NUM_OUT; j++) begin
            pop[j] = (cnt[j] != 2'd0) && !out_full[j];
            if (cnt[j] != 2'd0) begin
                all_empty = 1'b0;
            end
        end
    end

    for (genvar j = 0; j < NUM_OUT; j++) begin : g_buf
        mdc_stream_buf2 #(.W(SIZE)) u_buf (
            .clock      (clock),
            .reset      (reset),
            .push_i     (push[j]),
            .push_dat_i (push_dat[j]),
            .pop_i      (pop[j]),
            .count_o    (cnt[j]),
            .head_o     (head[j])
        );
        assign out_data[j*SIZE +: SIZE] = head[j];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:    if (ID != active_id_q && id_ok) state_d = ST_DRAIN;
            ST_DRAIN:  if (all_empty) state_d = ST_SWITCH;
            ST_SWITCH: state_d = ST_RUN;
            default:   state_d = ST_RUN;
        endcase
    end

    always_comb begin
        cfg_busy = (state_q != ST_RUN);
    end

    // An ID that went invalid while draining leaves the old configuration in place.
    always_comb begin
        route_d     = route_q;
        active_id_d = active_id_q;
        if (state_q == ST_SWITCH && id_ok) begin
            active_id_d = ID;
            for (int j = 0; j < NUM_OUT; j++) begin
                route_d[j] = RW'(route_field(ROUTE_TBL_W'(ROUTE), 32'(ID), j, NUM_OUT, RW));
            end
        end
        err_set          = '0;
        err_set[ERR_OVF] = |(in_wr & in_full_c);
        err_set[ERR_ID]  = !id_ok && ((state_q == ST_RUN && ID != active_id_q) ||
                                      state_q == ST_SWITCH);
        err_d = (err_clr ? 2'b00 : err_q) | err_set;
        for (int j = 0; j < NUM_OUT; j++) begin
            tok_d[j] = tok_q[j] + 32'(pop[j]);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < NUM_OUT; j++) begin
                route_q[j] <= RW'(route_field(ROUTE_TBL_W'(ROUTE), 0, j, NUM_OUT, RW));
            end
            active_id_q <= '0;
            err_q       <= '0;
            tok_q       <= '0;
        end else begin
            route_q     <= route_d;
            active_id_q <= active_id_d;
            err_q       <= err_d;
            tok_q       <= tok_d;
        end
    end

    assign in_full   = in_full_c;
    assign out_wr    = pop;
    assign active_id = active_id_q;
    assign err       = err_q;
    assign tok_cnt   = tok_q;

endmodule

// File: tb/tb_mdc_stream_switch.sv
// Randomised bench for mdc_stream_switch against a queue-based token model of the switch.
module tb_mdc_stream_switch;

    localparam int NIN  = 2;
    localparam int NOUT = 2;
    localparam int W    = 32;
    localparam int NCFG = 4;
    localparam logic [15:0] RT = 16'h6814;

    logic              clock = 1'b0;
    logic              reset;
    logic [NIN*W-1:0]  in_data;
    logic [NIN-1:0]    in_wr;
    logic [NIN-1:0]    in_full;
    logic [NOUT*W-1:0] out_data;
    logic [NOUT-1:0]   out_wr;
    logic [NOUT-1:0]   out_full;
    logic [7:0]        ID;
    logic [7:0]        active_id;
    logic              cfg_busy;
    logic [1:0]        err;
    logic              err_clr;
    logic [NOUT*32-1:0] tok_cnt;

    always #5 clock = ~clock;

    mdc_stream_switch dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_wr     (in_wr),
        .in_full   (in_full),
        .out_data  (out_data),
        .out_wr    (out_wr),
        .out_full  (out_full),
        .ID        (ID),
        .active_id (active_id),
        .cfg_busy  (cfg_busy),
        .err       (err),
        .err_clr   (err_clr),
        .tok_cnt   (tok_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: active config, reconfiguration phase (0 running, 1 draining, 2 switching),
    // tokens in flight per output, sticky errors, delivered-token counts.
    int          m_id;
    int          m_phase;
    logic [31:0] mq [NOUT][$];
    logic [1:0]  m_err;
    logic [31:0] m_tok [NOUT];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int raw_field(int c, int j);
        logic [15:0] t;
        t = RT >> ((c * NOUT + j) * 2);
        return int'(t[1:0]);
    endfunction

    function automatic int dest(int c, int j);
        int r;
        r = raw_field(c, j);
        if (r >= NIN) return -1;
        for (int k = 0; k < j; k++) begin
            if (raw_field(c, k) == r) return -1;
        end
        return r;
    endfunction

    function automatic int owner_of(int c, int i);
        for (int j = 0; j < NOUT; j++) begin
            if (dest(c, j) == i) return j;
        end
        return -1;
    endfunction

    task automatic m_reset();
        m_id    = 0;
        m_phase = 0;
        m_err   = 2'b00;
        for (int j = 0; j < NOUT; j++) begin
            mq[j].delete();
            m_tok[j] = 32'd0;
        end
    endtask

    // Called just after a falling edge with inputs already driven; checks, then advances the model.
    task automatic tick();
        bit         exp_full [NIN];
        bit         exp_wr [NOUT];
        bit         empty;
        int         o;
        logic [1:0] set;
        #1;
        if (!reset) m_reset();
        for (int i = 0; i < NIN; i++) begin
            o = owner_of(m_id, i);
            exp_full[i] = (o < 0) || (m_phase != 0) || (mq[o].size() == 2);
            chk("in_full", 64'(in_full[i]), 64'(exp_full[i]));
        end
        for (int j = 0; j < NOUT; j++) begin
            exp_wr[j] = (mq[j].size() > 0) && !out_full[j];
            chk("out_wr", 64'(out_wr[j]), 64'(exp_wr[j]));
            if (exp_wr[j]) chk("out_data", 64'(out_data[j*W +: W]), 64'(mq[j][0]));
            chk("tok_cnt", 64'(tok_cnt[j*32 +: 32]), 64'(m_tok[j]));
        end
        chk("cfg_busy", 64'(cfg_busy), 64'(m_phase != 0));
        chk("active_id", 64'(active_id), 64'(m_id));
        chk("err", 64'(err), 64'(m_err));
        if (reset) begin
            empty = 1'b1;
            for (int j = 0; j < NOUT; j++) if (mq[j].size() != 0) empty = 1'b0;
            for (int j = 0; j < NOUT; j++) begin
                if (exp_wr[j]) begin
                    void'(mq[j].pop_front());
                    m_tok[j] = m_tok[j] + 32'd1;
                end
            end
            set = 2'b00;
            for (int i = 0; i < NIN; i++) begin
                if (in_wr[i]) begin
                    if (exp_full[i]) set[0] = 1'b1;
                    else mq[owner_of(m_id, i)].push_back(in_data[i*W +: W]);
                end
            end
            case (m_phase)
                0: if (int'(ID) != m_id) begin
                       if (int'(ID) < NCFG) m_phase = 1;
                       else set[1] = 1'b1;
                   end
                1: if (empty) m_phase = 2;
                default: begin
                    if (int'(ID) < NCFG) m_id = int'(ID);
                    else set[1] = 1'b1;
                    m_phase = 0;
                end
            endcase
            m_err = (err_clr ? 2'b00 : m_err) | set;
        end
        @(negedge clock);
    endtask

    task automatic drive(input logic [1:0] wr, input logic [31:0] d0, input logic [31:0] d1);
        in_wr   = wr;
        in_data = {d1, d0};
    endtask

    task automatic idle(input int n);
        drive(2'b00, 32'd0, 32'd0);
        for (int k = 0; k < n; k++) tick();
    endtask

    initial begin
        bit fan;
        fan = 1'b0;
        for (int c = 0; c < NCFG; c++)
            for (int j = 0; j < NOUT; j++)
                for (int k = j + 1; k < NOUT; k++)
                    if (raw_field(c, j) < NIN && raw_field(c, j) == raw_field(c, k)) fan = 1'b1;
        assert (!fan) else $error("route table contains fan-out entries");

        reset    = 1'b0;
        in_wr    = '0;
        in_data  = '0;
        out_full = '0;
        ID       = 8'd0;
        err_clr  = 1'b0;
        m_reset();
        @(negedge clock);
        idle(2);
        reset = 1'b1;
        idle(1);

        // Identity routing, first token one cycle after acceptance.
        drive(2'b01, 32'h11, 32'h0);  tick();
        drive(2'b11, 32'h22, 32'h33); tick();
        idle(3);

        // Reconfigure to swap with three tokens parked behind a stalled output.
        out_full = 2'b11;
        drive(2'b11, 32'hA1, 32'hB1); tick();
        drive(2'b01, 32'hA2, 32'h0);  tick();
        drive(2'b00, 32'h0, 32'h0);
        ID = 8'd1;
        for (int k = 0; k < 5; k++) tick();
        out_full = 2'b00;
        idle(5);
        drive(2'b01, 32'hC1, 32'h0);  tick();
        drive(2'b11, 32'hC2, 32'hD1); tick();
        idle(3);

        // Half-connected configuration: in1 unrouted, out1 disconnected.
        ID = 8'd2;
        idle(4);
        drive(2'b10, 32'h0, 32'hE1);  tick();
        drive(2'b01, 32'hE2, 32'h0);  tick();
        idle(1);
        err_clr = 1'b1; idle(1); err_clr = 1'b0;
        idle(2);

        // Back to identity, then overflow a stalled output.
        ID = 8'd0;
        idle(4);
        out_full = 2'b01;
        drive(2'b01, 32'hF1, 32'h0); tick();
        drive(2'b01, 32'hF2, 32'h0); tick();
        drive(2'b01, 32'hF3, 32'h0); tick();
        drive(2'b00, 32'h0, 32'h0);  tick();
        out_full = 2'b00;
        idle(4);
        err_clr = 1'b1; idle(1); err_clr = 1'b0;

        // Out-of-range ID must not disturb traffic.
        ID = 8'd9;
        for (int k = 0; k < 6; k++) begin
            drive(2'b11, $urandom, $urandom); tick();
        end
        idle(2);
        ID = 8'd0;
        err_clr = 1'b1; idle(1); err_clr = 1'b0;

        // Reset in the middle of a drain.
        out_full = 2'b11;
        drive(2'b11, 32'h51, 32'h61); tick();
        drive(2'b00, 32'h0, 32'h0);
        ID = 8'd3;
        idle(3);
        reset = 1'b0;
        ID    = 8'd0;
        idle(2);
        reset    = 1'b1;
        out_full = 2'b00;
        drive(2'b11, 32'h71, 32'h81); tick();
        idle(3);

        // Random traffic with random stalls, reconfigurations and clears.
        for (int k = 0; k < 600; k++) begin
            drive(2'($urandom), $urandom, $urandom);
            out_full = 2'(($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b00);
            if ($urandom_range(0, 24) == 0) ID = 8'($urandom_range(0, 5));
            err_clr = ($urandom_range(0, 15) == 0);
            tick();
        end
        err_clr  = 1'b0;
        out_full = 2'b00;
        idle(6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
